// File: rtl/flash_write_engine_pkg.sv
// Shared types and constants for the flash write engine.
// Holds FSM state codes, operation types, fill pattern and byte merge.
package flash_pkg;

  localparam int PAGE_WORDS = 32;

  localparam logic WRITE_TYPE_PROGRAM = 1'b0;
  localparam logic WRITE_TYPE_ERASE   = 1'b1;

  localparam logic [63:0] ERASE_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ARMED    = 3'd1;
  localparam state_t ST_ERASE_WR = 3'd2;
  localparam state_t ST_PRG_BUF  = 3'd3;
  localparam state_t ST_PRG_RD   = 3'd4;
  localparam state_t ST_PRG_WR   = 3'd5;
  localparam state_t ST_NEXT     = 3'd6;
  localparam state_t ST_DONE     = 3'd7;

  // Programming can only clear bits: unwritten bytes keep old data.
  function automatic logic [63:0] merge_word(
    input logic [63:0] old_w,
    input logic [63:0] new_w,
    input logic [7:0]  flags
  );
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = old_w[8*b +: 8]
                  & (flags[b] ? new_w[8*b +: 8] : 8'hFF);
    end
    return r;
  endfunction

endpackage

// File: rtl/flash_write_engine_if.sv
// SDRAM read/write request bundle between engine and controller.
// master = engine (drives requests), slave = SDRAM controller.
interface flash_write_engine_if #(
  parameter int ADDR_W = 22
);
  logic              ram_rd_req;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [63:0]       ram_rd_data;
  logic              ram_rd_valid;
  logic              ram_wr_req;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [63:0]       ram_wr_data;
  logic [7:0]        ram_wr_mask;
  logic              ram_wr_ack;

  modport master (
    output ram_rd_req, ram_rd_addr,
    input  ram_rd_data, ram_rd_valid,
    output ram_wr_req, ram_wr_addr,
    output ram_wr_data, ram_wr_mask,
    input  ram_wr_ack
  );

  modport slave (
    input  ram_rd_req, ram_rd_addr,
    output ram_rd_data, ram_rd_valid,
    input  ram_wr_req, ram_wr_addr,
    input  ram_wr_data, ram_wr_mask,
    output ram_wr_ack
  );
endinterface

// File: rtl/flash_write_engine_sync.sv
// Single-bit synchroniser: STAGES flip-flops, cleared on reset.
// Ports: clk, reset, d (async in), q (synchronised out).
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= (chain << 1) | STAGES'(d);
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/flash_write_engine.sv
// Executes flash erase / page-program ops as SDRAM writes.
// Ports: command in, page buffer read port, SDRAM bus (ram), write_done.
module flash_write_engine #(
  parameter int ADDR_W      = 22,
  parameter int PAGE_WORDS  = flash_pkg::PAGE_WORDS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_active,
  input  logic              write_cmd,
  input  logic              write_type,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [12:0]       write_len,
  output logic              write_done,
  output logic [4:0]        buf_rd_addr,
  input  logic [63:0]       buf_rd_data,
  input  logic [7:0]        buf_rd_valid,
  output logic              buf_clear,
  flash_write_engine_if.master ram
);
  import flash_pkg::*;

  logic cmd_s, act_s, cmd_q, act_q;
  logic cmd_rise, cs_rise;

  state_t            state;
  logic              op_type;
  logic [ADDR_W-1:0] base;
  logic [12:0]       len;
  logic [12:0]       idx;
  logic              ph;
  logic [63:0]       new_w, old_w;
  logic [7:0]        flags;

  logic [ADDR_W-1:0] erase_addr, page_addr;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cmd (
    .clk(clk), .reset(reset), .d(write_cmd), .q(cmd_s)
  );

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_act (
    .clk(clk), .reset(reset), .d(spi_active), .q(act_s)
  );

  assign cmd_rise = cmd_s & ~cmd_q;
  // chip-select deasserting ends the SPI transaction
  assign cs_rise  = act_q & ~act_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q      <= 1'b0;
      act_q      <= 1'b0;
      state      <= ST_IDLE;
      op_type    <= WRITE_TYPE_PROGRAM;
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      ph         <= 1'b0;
      new_w      <= '0;
      old_w      <= '0;
      flags      <= '0;
      write_done <= 1'b0;
    end else begin
      cmd_q <= cmd_s;
      act_q <= act_s;
      case (state)
        ST_IDLE: begin
          if (cmd_rise) begin
            op_type    <= write_type;
            base       <= write_addr;
            len        <= write_len;
            idx        <= '0;
            write_done <= 1'b0;
            state      <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (cs_rise) begin
            idx   <= '0;
            ph    <= 1'b0;
            state <= (op_type == WRITE_TYPE_ERASE)
                   ? ST_ERASE_WR : ST_PRG_BUF;
          end else if (!cmd_s) begin
            state <= ST_IDLE;
          end
        end
        ST_ERASE_WR: begin
          if (ram.ram_wr_ack) begin
            if (idx == len) state <= ST_DONE;
            else            idx   <= idx + 13'd1;
          end
        end
        ST_PRG_BUF: begin
          // ph=0: address presented; ph=1: read data valid
          if (!ph) begin
            ph <= 1'b1;
          end else begin
            ph <= 1'b0;
            if (buf_rd_valid == 8'h00) begin
              state <= ST_NEXT;
            end else begin
              new_w <= buf_rd_data;
              flags <= buf_rd_valid;
              state <= ST_PRG_RD;
            end
          end
        end
        ST_PRG_RD: begin
          if (ram.ram_rd_valid) begin
            old_w <= ram.ram_rd_data;
            state <= ST_PRG_WR;
          end
        end
        ST_PRG_WR: begin
          if (ram.ram_wr_ack) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (idx == 13'(PAGE_WORDS - 1)) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 13'd1;
            state <= ST_PRG_BUF;
          end
        end
        ST_DONE: begin
          write_done <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign erase_addr = base + ADDR_W'(idx);
  assign page_addr  = {base[ADDR_W-1:5], idx[4:0]};

  assign buf_rd_addr = idx[4:0];
  assign buf_clear   = (state == ST_DONE)
                     & (op_type == WRITE_TYPE_PROGRAM);

  always_comb begin
    ram.ram_rd_req  = 1'b0;
    ram.ram_rd_addr = '0;
    ram.ram_wr_req  = 1'b0;
    ram.ram_wr_addr = '0;
    ram.ram_wr_data = '0;
    ram.ram_wr_mask = '0;
    unique case (1'b1)
      (state == ST_ERASE_WR): begin
        ram.ram_wr_req  = 1'b1;
        ram.ram_wr_addr = erase_addr;
        ram.ram_wr_data = ERASE_FILL;
        ram.ram_wr_mask = 8'hFF;
      end
      (state == ST_PRG_RD): begin
        ram.ram_rd_req  = 1'b1;
        ram.ram_rd_addr = page_addr;
      end
      (state == ST_PRG_WR): begin
        ram.ram_wr_req  = 1'b1;
        ram.ram_wr_addr = page_addr;
        ram.ram_wr_data = merge_word(old_w, new_w, flags);
        ram.ram_wr_mask = flags;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_write_engine.sv
// Scoreboard bench for flash_write_engine.
// SDRAM/page-buffer models on negedge; monitor pops expected writes.
module tb_flash_write_engine;

  localparam int AW = 22;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [63:0]   d;
    logic [7:0]    m;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_active = 1'b0;
  logic          write_cmd = 1'b0;
  logic          write_type = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [12:0]   write_len = '0;
  logic          write_done;
  logic [4:0]    buf_rd_addr;
  logic [63:0]   buf_rd_data = '1;
  logic [7:0]    buf_rd_valid = '0;
  logic          buf_clear;

  flash_write_engine_if #(.ADDR_W(AW)) ram ();

  flash_write_engine #(
    .ADDR_W(AW), .PAGE_WORDS(32), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .spi_active(spi_active), .write_cmd(write_cmd),
    .write_type(write_type), .write_addr(write_addr),
    .write_len(write_len), .write_done(write_done),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .buf_rd_valid(buf_rd_valid), .buf_clear(buf_clear),
    .ram(ram)
  );

  always #5 clk = ~clk;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  int errors = 0;
  int checks = 0;
  int wr_delay = 0;
  int rd_delay = 2;
  int n_wr = 0, n_rd = 0, n_clr = 0;
  logic [63:0] bufdata[32];
  logic [7:0]  bufflag[32];
  logic [63:0] mem[int];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM responder, page-buffer model and scoreboard monitor
  initial begin : model
    int wr_cnt, rd_cnt;
    logic p_wr, p_rd, p_rst, p_ack;
    wr_t  p_txn, cur;
    wr_t  e;
    logic [AW-1:0] ea;
    wr_cnt = 0; rd_cnt = 0;
    p_wr = 0; p_rd = 0; p_rst = 1; p_ack = 0;
    p_txn = '0;
    ram.ram_wr_ack = 0;
    ram.ram_rd_valid = 0;
    ram.ram_rd_data = '0;
    for (int k = 0; k < 32; k++) begin
      bufdata[k] = '1;
      bufflag[k] = '0;
    end
    forever begin
      @(negedge clk);
      cur = {ram.ram_wr_addr, ram.ram_wr_data, ram.ram_wr_mask};
      if (!reset && !p_rst) begin
        if (p_wr && !p_ack) begin
          chk("wr_hold_req", ram.ram_wr_req, 1'b1);
          chk("wr_hold_bus", cur, p_txn);
        end
        if (ram.ram_wr_req || ram.ram_rd_req)
          chk("one_req", ram.ram_wr_req & ram.ram_rd_req, 1'b0);
      end
      if (buf_clear) begin
        n_clr++;
        for (int k = 0; k < 32; k++) begin
          bufdata[k] = '1;
          bufflag[k] = '0;
        end
      end
      buf_rd_data  = bufdata[buf_rd_addr];
      buf_rd_valid = bufflag[buf_rd_addr];
      ram.ram_wr_ack   = 0;
      ram.ram_rd_valid = 0;
      if (ram.ram_wr_req && !reset) begin
        if (wr_cnt >= wr_delay) begin
          ram.ram_wr_ack = 1;
          wr_cnt = 0;
          n_wr++;
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got %h expected none", cur);
          end else begin
            checks--;
            e = exp_wr.pop_front();
            chk("wr_txn", cur, e);
          end
        end else wr_cnt++;
      end else wr_cnt = 0;
      if (ram.ram_rd_req && !reset) begin
        if (rd_cnt >= rd_delay) begin
          ram.ram_rd_valid = 1;
          rd_cnt = 0;
          n_rd++;
          ram.ram_rd_data = mem.exists(int'(ram.ram_rd_addr))
                          ? mem[int'(ram.ram_rd_addr)] : '1;
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %h expected none",
                     ram.ram_rd_addr);
          end else begin
            checks--;
            ea = exp_rd.pop_front();
            chk("rd_addr", ram.ram_rd_addr, ea);
          end
        end else rd_cnt++;
      end else rd_cnt = 0;
      p_wr  = ram.ram_wr_req;
      p_rd  = ram.ram_rd_req;
      p_ack = ram.ram_wr_ack;
      p_rst = reset;
      p_txn = cur;
    end
  end

  task automatic start_op(input logic t,
                          input logic [AW-1:0] a,
                          input logic [12:0] l);
    @(negedge clk);
    spi_active = 1;
    write_type = t;
    write_addr = a;
    write_len  = l;
    repeat (2) @(negedge clk);
    write_cmd = 1;
    repeat (8) @(negedge clk);
    spi_active = 0;
  endtask

  task automatic wait_done(input int max, input string name);
    int k;
    k = 0;
    while (!write_done && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(name, write_done, 1'b1);
    write_cmd = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic push_erase(input logic [AW-1:0] b, input int n);
    for (int k = 0; k < n; k++)
      exp_wr.push_back({b + AW'(k), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF});
  endtask

  initial begin : stim
    int w0, r0, c0, k;
    repeat (3) @(negedge clk);
    chk("rst_done", write_done, 1'b0);
    chk("rst_wr_req", ram.ram_wr_req, 1'b0);
    chk("rst_rd_req", ram.ram_rd_req, 1'b0);
    chk("rst_clear", buf_clear, 1'b0);
    chk("rst_wr_bus", {ram.ram_wr_addr, ram.ram_wr_data,
                       ram.ram_wr_mask}, '0);
    chk("rst_rd_addr", ram.ram_rd_addr, '0);
    reset = 0;
    repeat (2) @(negedge clk);

    // subsector erase
    wr_delay = 0;
    w0 = n_wr; c0 = n_clr;
    push_erase(22'h001000, 512);
    start_op(1'b1, 22'h001000, 13'h1FF);
    wait_done(3000, "erase_done");
    chk("erase_count", n_wr - w0, 512);
    chk("erase_q_empty", exp_wr.size(), 0);
    chk("erase_no_clear", n_clr - c0, 0);

    // program one word; low address bits of base are ignored
    bufdata[3] = 64'h0000_0000_0000_00AA;
    bufflag[3] = 8'h01;
    mem[int'(22'h040023)] = 64'h0F0F_0F0F_0F0F_0F0F;
    w0 = n_wr; r0 = n_rd; c0 = n_clr;
    exp_rd.push_back(22'h040023);
    exp_wr.push_back({22'h040023, 64'h0F0F_0F0F_0F0F_0F0A, 8'h01});
    start_op(1'b0, 22'h040027, 13'd1);
    wait_done(1000, "prog1_done");
    chk("prog1_wr", n_wr - w0, 1);
    chk("prog1_rd", n_rd - r0, 1);
    chk("prog1_clear", n_clr - c0, 1);
    chk("prog1_q_empty", exp_wr.size() + exp_rd.size(), 0);

    // program with empty buffer
    w0 = n_wr; r0 = n_rd; c0 = n_clr;
    start_op(1'b0, 22'h000100, 13'd0);
    wait_done(1000, "empty_done");
    chk("empty_traffic", (n_wr - w0) + (n_rd - r0), 0);
    chk("empty_clear", n_clr - c0, 1);

    // abort: command withdrawn while chip-select still active
    w0 = n_wr; r0 = n_rd; c0 = n_clr;
    @(negedge clk);
    spi_active = 1;
    write_type = 1;
    write_addr = 22'h000200;
    write_len  = 13'h1FF;
    repeat (2) @(negedge clk);
    write_cmd = 1;
    repeat (8) @(negedge clk);
    write_cmd = 0;
    repeat (8) @(negedge clk);
    spi_active = 0;
    repeat (12) @(negedge clk);
    chk("abort_done", write_done, 1'b0);
    chk("abort_traffic", (n_wr - w0) + (n_rd - r0), 0);
    chk("abort_clear", n_clr - c0, 0);

    // erase with write backpressure and address wrap
    wr_delay = 20;
    w0 = n_wr;
    push_erase(22'h3FFF00, 512);
    start_op(1'b1, 22'h3FFF00, 13'h1FF);
    wait_done(20000, "bp_done");
    chk("bp_count", n_wr - w0, 512);
    chk("bp_q_empty", exp_wr.size(), 0);

    // reset in the middle of an erase
    wr_delay = 0;
    w0 = n_wr;
    push_erase(22'h002000, 512);
    start_op(1'b1, 22'h002000, 13'h1FF);
    k = 0;
    while ((n_wr - w0) < 100 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached", (n_wr - w0) >= 100, 1'b1);
    reset = 1;
    write_cmd = 0;
    @(negedge clk);
    chk("mid_rst_req", {ram.ram_wr_req, ram.ram_rd_req}, 2'b00);
    chk("mid_rst_bus", {ram.ram_wr_addr, ram.ram_wr_data,
                        ram.ram_wr_mask}, '0);
    chk("mid_rst_done", write_done, 1'b0);
    chk("mid_rst_clear", buf_clear, 1'b0);
    #2 reset = 0;
    exp_wr.delete();
    repeat (3) @(negedge clk);

    // new program after reset: two words incl. the last index
    bufdata[5]  = 64'h1234_5678_9ABC_DEF0;
    bufflag[5]  = 8'hF0;
    bufdata[31] = 64'h7F00_0000_0000_0000;
    bufflag[31] = 8'h80;
    mem[int'(22'h012345)] = 64'hFF00_FF00_FFFF_FFFF;
    w0 = n_wr; r0 = n_rd; c0 = n_clr;
    exp_rd.push_back(22'h012345);
    exp_rd.push_back(22'h01235F);
    exp_wr.push_back({22'h012345, 64'h1200_5600_FFFF_FFFF, 8'hF0});
    exp_wr.push_back({22'h01235F, 64'h7FFF_FFFF_FFFF_FFFF, 8'h80});
    start_op(1'b0, 22'h012340, 13'd0);
    wait_done(1000, "prog2_done");
    chk("prog2_wr", n_wr - w0, 2);
    chk("prog2_rd", n_rd - r0, 2);
    chk("prog2_clear", n_clr - c0, 1);
    chk("prog2_q_empty", exp_wr.size() + exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
